// File: rtl/pool_pkg.sv
// Shared types and helpers for the max-pooling datapath.
// Holds lane width, kernel-counter widths, the control state enum,
// a signed max and the last-position decode used by lanes and control.
package pool_pkg;

  localparam int DATA_W = 8;
  localparam int KCNT_W = 2;
  localparam int DIM_W  = 3;

  typedef enum logic {POOL_IDLE, POOL_RUN} pool_state_e;

  function automatic logic signed [DATA_W-1:0] smax(
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b
  );
    return (a > b) ? a : b;
  endfunction

  // dim==0 is illegal: nothing ever counts as the last position.
  function automatic logic is_last(
    input logic [KCNT_W-1:0] x,
    input logic [KCNT_W-1:0] y,
    input logic [DIM_W-1:0]  dim
  );
    return (dim != '0) &&
           (DIM_W'(x) == dim - DIM_W'(1)) &&
           (DIM_W'(y) == dim - DIM_W'(1));
  endfunction

endpackage

// File: rtl/pool_max_lane.sv
// One pooling lane: running signed max over a window, optional ReLU.
// Result register updates one cycle after the last-position sample.
// No backpressure; a flagged sample is always consumed.
module pool_max_lane
  import pool_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flag_i,
  input  logic [KCNT_W-1:0]        kx_i,
  input  logic [KCNT_W-1:0]        ky_i,
  input  logic [DIM_W-1:0]         dim_i,
  input  logic                     relu_en_i,
  input  logic signed [DATA_W-1:0] data_i,
  output logic                     last_o,
  output logic signed [DATA_W-1:0] res_o
);

  logic signed [DATA_W-1:0] acc_q, acc_d;
  logic signed [DATA_W-1:0] res_q, res_d;
  logic signed [DATA_W-1:0] win_max;
  logic                     first_pos;
  logic                     dim_ok;

  // Accumulator and result next-state; illegal dim freezes the accumulator.
  always_comb begin
    acc_d     = acc_q;
    res_d     = res_q;
    dim_ok    = (dim_i != '0);
    first_pos = (kx_i == '0) && (ky_i == '0);
    last_o    = flag_i && is_last(kx_i, ky_i, dim_i);
    win_max   = (dim_i == DIM_W'(1)) ? data_i : smax(acc_q, data_i);
    if (flag_i && dim_ok) begin
      acc_d = first_pos ? data_i : smax(acc_q, data_i);
    end
    if (last_o) begin
      res_d = (relu_en_i && win_max[DATA_W-1]) ? '0 : win_max;
    end
  end

  // Lane state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      res_q <= '0;
    end else begin
      acc_q <= acc_d;
      res_q <= res_d;
    end
  end

  assign res_o = res_q;

endmodule

// File: rtl/pool_max_array.sv
// Per-column max pooling with output addressing and controller handshake.
// One cycle from last-position sample to out_valid/out_data/out_addr.
// No backpressure: the consumer must take one word per cycle.
module pool_max_array #(
  parameter int COLS   = 4,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [COLS-1:0]        pooling_signal_o,
  input  logic [COLS-1:0]        input_flag_pl_o,
  input  logic [1:0]             cnt_pl_kernel_x,
  input  logic [1:0]             cnt_pl_kernel_y,
  input  logic [2:0]             pooling_kernel_dim,
  input  logic                   relu_en,
  input  logic [ADDR_W-1:0]      out_base_addr,
  input  logic [COLS*DATA_W-1:0] data_in,
  output logic                   out_valid,
  output logic [COLS*DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0]      out_addr,
  output logic                   out_flag_pooling,
  output logic                   pool_done
);

  logic [COLS-1:0]        lane_last;
  logic [COLS*DATA_W-1:0] lane_res;

  genvar gi;
  generate
    for (gi = 0; gi < COLS; gi++) begin : g_lane
      pool_max_lane u_lane (
        .clk       (clk),
        .rst       (rst),
        .flag_i    (input_flag_pl_o[gi]),
        .kx_i      (cnt_pl_kernel_x),
        .ky_i      (cnt_pl_kernel_y),
        .dim_i     (pooling_kernel_dim),
        .relu_en_i (relu_en),
        .data_i    (data_in[gi*DATA_W +: DATA_W]),
        .last_o    (lane_last[gi]),
        .res_o     (lane_res[gi*DATA_W +: DATA_W])
      );
    end
  endgenerate

  assign out_data = lane_res;

  // The controller drives every lane identically, so only lane 0 steers control.
  logic unused_ok;
  assign unused_ok = ^{lane_last, pooling_signal_o};

  pool_pkg::pool_state_e state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d, cur_addr;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d;
  logic emitted_q, emitted_d;
  logic done_pend_q, done_pend_d;
  logic out_valid_q, out_valid_d;
  logic flag_q, flag_d;
  logic pool_done_q, pool_done_d;
  logic sig, last0, period_end;

  // Lane-0 FSM, address counter and pulse generation.
  always_comb begin
    sig         = pooling_signal_o[0];
    last0       = lane_last[0];
    state_d     = state_q;
    period_end  = (state_q == pool_pkg::POOL_RUN) && !sig;
    cur_addr    = (state_q == pool_pkg::POOL_IDLE) ? out_base_addr : cnt_q;
    out_addr_d  = last0 ? cur_addr : out_addr_q;
    cnt_d       = last0 ? cur_addr + ADDR_W'(1) : cur_addr;
    emitted_d   = sig ? (emitted_q || last0) : 1'b0;
    // pool_done trails the final word by one cycle when both land together.
    done_pend_d = period_end && (emitted_q || last0);
    pool_done_d = done_pend_q;
    out_valid_d = last0;
    flag_d      = last0 && sig;
    if (period_end) begin
      cnt_d = out_base_addr;
    end
    case (state_q)
      pool_pkg::POOL_IDLE: if (sig)  state_d = pool_pkg::POOL_RUN;
      pool_pkg::POOL_RUN:  if (!sig) state_d = pool_pkg::POOL_IDLE;
      default:             state_d = pool_pkg::POOL_IDLE;
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= pool_pkg::POOL_IDLE;
      cnt_q       <= '0;
      out_addr_q  <= '0;
      emitted_q   <= 1'b0;
      done_pend_q <= 1'b0;
      out_valid_q <= 1'b0;
      flag_q      <= 1'b0;
      pool_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_addr_q  <= out_addr_d;
      emitted_q   <= emitted_d;
      done_pend_q <= done_pend_d;
      out_valid_q <= out_valid_d;
      flag_q      <= flag_d;
      pool_done_q <= pool_done_d;
    end
  end

  assign out_valid        = out_valid_q;
  assign out_addr         = out_addr_q;
  assign out_flag_pooling = flag_q;
  assign pool_done        = pool_done_q;

endmodule
